pcie_egress_drain: RTL and testbench
====================================

Name: pcie_egress_drain

Overview:
- Consumer side of the switch's four egress FIFOs (destination ports 0-3).
- Generates the per-port pop strobes from the empty flags and reads the words out in round-robin order.
- Presents the words as a single tagged output stream and checks that the destination field of each word matches the port it came from.
- Keeps per-port delivered-word counters and an error counter.

Parameters:
TAMANO_DATOS, 12, word width; destination field is bits [9:8]
CNT_WIDTH, 8, width of each delivered-word counter and of the error counter

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low; 0 = reset
enable  input  1  1 = drain FIFOs; 0 = stop issuing pops
sink_ready  input  1  downstream can take new words; 0 blocks new pops
empty  input  4  empty flags of egress FIFOs, bit i = port i
data_in0  input  TAMANO_DATOS  data_out of port-0 FIFO
data_in1  input  TAMANO_DATOS  data_out of port-1 FIFO
data_in2  input  TAMANO_DATOS  data_out of port-2 FIFO
data_in3  input  TAMANO_DATOS  data_out of port-3 FIFO
count_sel  input  2  selects which port counter appears on count_out
pop  output  4  one-hot read enable to egress FIFOs
data_out  output  TAMANO_DATOS  delivered word
valid_out  output  1  data_out/port_out valid, one cycle per word
port_out  output  2  index of the port the word came from
mismatch  output  1  1-cycle pulse, aligned with valid_out, when data_out[9:8] != port_out
count_out  output  CNT_WIDTH  delivered-word count of port count_sel
err_count  output  CNT_WIDTH  total mismatches, saturating
idle  output  1  state IDLE and no word in flight

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - pop=0, data_out=0, valid_out=0, port_out=0, mismatch=0;
  - all counters 0, err_count=0, count_out=0;
  - round-robin pointer rr=0; state=IDLE, idle=1.
  - A word in flight is discarded, with no valid_out.
- FIFO read latency is 1: the word popped in cycle N is on data_inX during cycle N+1 and is registered into data_out at the end of N+1. valid_out is therefore high in cycle N+2.
- pop is combinational from state and registered flags; it must be glitch-free at most one-hot.
- States:
  - IDLE: pop=0. Goes to RUN when enable=1.
  - RUN: issues pops. Goes to DRAIN when enable=0.
  - DRAIN: pop=0. If a pop was issued in the previous cycle, stays one cycle to capture that word, then goes to IDLE. Otherwise goes directly to IDLE. If enable returns to 1 in DRAIN, goes to RUN.
- Eligibility for a pop in RUN: port i is eligible when empty[i]==0, sink_ready==1, and port i was not popped in the previous cycle. The back-to-back mask covers the one-cycle lag of the empty flag after a pop.
- Arbitration:
  - Grant the first eligible port scanning rr, rr+1, … (mod 4). Assert pop[grant] for one cycle, then rr <= grant+1 (mod 4).
  - With no eligible port, pop=0 and rr is unchanged.
  - A single non-empty port drains at most every other cycle; two or more non-empty ports drain every cycle.
- Capture stage:
  - A registered copy of pop (pop_d) selects data_in[pop_d].
  - On the next edge: data_out <= selected word, port_out <= index, valid_out <= 1.
  - When pop_d==0, valid_out <= 0 and data_out/port_out hold their values.
- sink_ready=0 blocks only new pops. A word already popped is still delivered, so the sink must absorb one residual word.
- Check: when a word is captured and word[9:8] != index, mismatch=1 in the same cycle as valid_out and err_count increments, saturating at 2^CNT_WIDTH-1. The word is still delivered.
- Counters: cnt[i] increments when a port-i word is delivered (valid_out rising with port_out=i), saturating at 2^CNT_WIDTH-1.
- count_out <= cnt[count_sel] each cycle, i.e. one cycle of latency from count_sel.
- Simultaneous events:
  - enable falling in the cycle a pop is issued: that pop still completes via DRAIN.
  - A counter read of the port being incremented returns the pre-increment value.

Test Plan:
- Reset: reset=0 for 2 cycles with all empty=0 and enable=1 → pop=0, valid_out=0, count_out=0, idle=1; the first pop appears in the second cycle after reset is released.
- Round-robin: all four FIFOs hold 2 words with matching dest fields, enable=1, sink_ready=1 → pop sequence 0001,0010,0100,1000,0001,…; port_out 0,1,2,3,0,1,2,3; 8 valid_out cycles back-to-back; cnt[i]=2 each; err_count=0.
- Single port: only port 2 non-empty, holding 3 words → pop[2] in alternating cycles; 3 words delivered in 5 cycles (N+2, N+4, N+6); idle=1 once empty[2]=1.
- Mismatch: port 1 word 12'h300 (dest=3) → mismatch pulse with valid_out, port_out=1, data_out=12'h300, err_count=1; fill the FIFO with 300 such words → err_count saturates at 255.
- Backpressure/drain: drop sink_ready in the cycle after pop[0] → that word is still delivered; no further pops until sink_ready=1. Drop enable during a pop → state passes through DRAIN, the word is delivered, then IDLE.
- Reset mid-stream: reset=0 in the cycle after a pop → no valid_out for that word; all counters 0.

Source files
------------

// File: rtl/pcie_egress_drain.sv
// Egress drain: round-robin pops from four egress FIFOs, tags each word with
// its source port, flags destination mismatches and counts delivered words.
module pcie_egress_drain #(
  parameter int unsigned TAMANO_DATOS = 12,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sink_ready,
  input  logic [3:0]              empty,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic [1:0]              count_sel,
  output logic [3:0]              pop,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic [1:0]              port_out,
  output logic                    mismatch,
  output logic [CNT_WIDTH-1:0]    count_out,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    idle
);

  localparam int unsigned DEST_LSB = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [3:0]                pop_d;
  logic [1:0]                rr;
  logic [CNT_WIDTH-1:0]      cnt [4];

  logic [3:0]                elig;
  logic [1:0]                grant;
  logic [1:0]                idx;
  logic                      found;
  logic [TAMANO_DATOS-1:0]   cap_word;
  logic [1:0]                cap_idx;
  logic                      cap_bad;

  // Round-robin grant; a port popped last cycle is masked because its empty flag lags.
  always_comb begin
    elig  = '0;
    pop   = '0;
    grant = rr;
    idx   = rr;
    found = 1'b0;
    if (state == RUN) begin
      elig = ~empty & ~pop_d & {4{sink_ready}};
    end
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    if (found) begin
      pop[grant] = 1'b1;
    end
  end

  // Next-state decode; DRAIN lingers one cycle while a popped word is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)              state_nxt = RUN;
        else if (pop_d != 4'd0)  state_nxt = DRAIN;
        else                     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the word arriving from the port popped last cycle.
  always_comb begin
    cap_word = data_in0;
    cap_idx  = 2'd0;
    if (pop_d[1]) begin
      cap_word = data_in1;
      cap_idx  = 2'd1;
    end else if (pop_d[2]) begin
      cap_word = data_in2;
      cap_idx  = 2'd2;
    end else if (pop_d[3]) begin
      cap_word = data_in3;
      cap_idx  = 2'd3;
    end
    cap_bad = (cap_word[DEST_LSB +: 2] != cap_idx);
  end

  // State, arbitration pointer, capture stage and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pop_d     <= '0;
      rr        <= 2'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
      port_out  <= 2'd0;
      mismatch  <= 1'b0;
      count_out <= '0;
      err_count <= '0;
      idle      <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      pop_d     <= pop;
      idle      <= (state_nxt == IDLE) && (pop == 4'd0);
      count_out <= cnt[count_sel];
      if (found) begin
        rr <= grant + 2'd1;
      end
      if (pop_d != 4'd0) begin
        data_out  <= cap_word;
        port_out  <= cap_idx;
        valid_out <= 1'b1;
        mismatch  <= cap_bad;
        if (cap_bad && (err_count != CNT_MAX)) begin
          err_count <= err_count + CNT_WIDTH'(1);
        end
        if (cnt[cap_idx] != CNT_MAX) begin
          cnt[cap_idx] <= cnt[cap_idx] + CNT_WIDTH'(1);
        end
      end else begin
        valid_out <= 1'b0;
        mismatch  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_egress_drain.sv
// Directed bench for pcie_egress_drain with a small 1-cycle-latency FIFO model.
module tb_pcie_egress_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sink_ready;
  logic [3:0]  empty = 4'hF;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic [1:0]  count_sel;
  logic [3:0]  pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic [1:0]  port_out;
  logic        mismatch;
  logic [7:0]  count_out;
  logic [7:0]  err_count;
  logic        idle;

  int n_chk  = 0;
  int n_pass = 0;

  pcie_egress_drain #(.TAMANO_DATOS(12), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sink_ready(sink_ready),
    .empty(empty), .data_in0(data_in0), .data_in1(data_in1),
    .data_in2(data_in2), .data_in3(data_in3), .count_sel(count_sel),
    .pop(pop), .data_out(data_out), .valid_out(valid_out), .port_out(port_out),
    .mismatch(mismatch), .count_out(count_out), .err_count(err_count), .idle(idle)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop; empty flag lags one cycle.
  logic [11:0] mem [4][512];
  int unsigned wr [4] = '{default: 0};
  int unsigned rd [4] = '{default: 0};
  logic [11:0] dq [4] = '{default: 12'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      empty[i] <= (wr[i] == rd[i]);
      if (pop[i]) begin
        dq[i] <= mem[i][9'(rd[i])];
        rd[i] <= rd[i] + 1;
      end
    end
  end

  assign data_in0 = dq[0];
  assign data_in1 = dq[1];
  assign data_in2 = dq[2];
  assign data_in3 = dq[3];

  task automatic push(input int p, input logic [11:0] w);
    mem[p][9'(wr[p])] = w;
    wr[p] = wr[p] + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Waits (bounded) for a cycle with a pop; returns at a sample point inside that cycle.
  task automatic wait_pop(input string tag);
    bit ok;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (pop != 4'd0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  function automatic logic [11:0] mk(input int p, input int j);
    return 12'(p * 256 + p * 16 + j);
  endfunction

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    sink_ready = 1'b1;
    count_sel  = 2'd0;

    // Reset with all FIFOs holding two correctly-tagged words.
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 2; j++) push(p, mk(p, j));
    repeat (2) @(negedge clk);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_mm", 32'(mismatch), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_pop_c1", 32'(pop), 32'd0);

    // Round-robin over four ports, two rounds back-to-back.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rr_pop%0d", k), 32'(pop), (k < 8) ? 32'(1 << (k % 4)) : 32'd0);
      check($sformatf("rr_valid%0d", k), 32'(valid_out), (k >= 2 && k < 10) ? 32'd1 : 32'd0);
      if (k >= 2 && k < 10) begin
        check($sformatf("rr_port%0d", k), 32'(port_out), 32'((k - 2) % 4));
        check($sformatf("rr_data%0d", k), 32'(data_out), 32'(mk((k - 2) % 4, (k - 2) / 4)));
        check($sformatf("rr_mm%0d", k), 32'(mismatch), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      count_sel = 2'(i);
      @(negedge clk);
      check($sformatf("rr_cnt%0d", i), 32'(count_out), 32'd2);
    end
    check("rr_err", 32'(err_count), 32'd0);

    // Single non-empty port drains every other cycle.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) push(2, 12'h2A0 + 12'(j));
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("sp_pop%0d", k), 32'(pop), (k == 0 || k == 2 || k == 4) ? 32'h4 : 32'd0);
      check($sformatf("sp_valid%0d", k), 32'(valid_out),
            (k == 2 || k == 4 || k == 6) ? 32'd1 : 32'd0);
      if (k == 2 || k == 4 || k == 6)
        check($sformatf("sp_data%0d", k), 32'(data_out), 32'(12'h2A0 + 12'((k - 2) / 2)));
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("sp_idle", 32'(idle), 32'd1);
    count_sel = 2'd2;
    @(negedge clk);
    check("sp_cnt2", 32'(count_out), 32'd5);

    // Destination mismatch and error-counter saturation.
    push(1, 12'h300);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mm_mm%0d", k), 32'(mismatch), (k == 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check("mm_valid", 32'(valid_out), 32'd1);
        check("mm_port", 32'(port_out), 32'd1);
        check("mm_data", 32'(data_out), 32'h300);
        check("mm_err1", 32'(err_count), 32'd1);
      end
    end
    for (int j = 0; j < 299; j++) push(1, 12'h300);
    repeat (650) @(negedge clk);
    check("mm_err_sat", 32'(err_count), 32'd255);
    count_sel = 2'd1;
    @(negedge clk);
    check("mm_cnt1_sat", 32'(count_out), 32'd255);

    // Backpressure: sink_ready drops the cycle after a pop.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 12'h0B0);
    push(0, 12'h0B1);
    enable = 1'b1;
    @(negedge clk);
    wait_pop("bp_first");
    check("bp_pop0", 32'(pop), 32'd1);
    @(posedge clk);
    #1 sink_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("bp_nopop%0d", k), 32'(pop), 32'd0);
      check($sformatf("bp_valid%0d", k), 32'(valid_out), (k == 2) ? 32'd1 : 32'd0);
      if (k == 2) check("bp_data0", 32'(data_out), 32'h0B0);
    end
    sink_ready = 1'b1;
    wait_pop("bp_resume");
    check("bp_pop1", 32'(pop), 32'd1);
    repeat (2) @(negedge clk);
    check("bp_valid_b1", 32'(valid_out), 32'd1);
    check("bp_data1", 32'(data_out), 32'h0B1);

    // enable falls in the pop cycle: word still delivered via DRAIN, then IDLE.
    push(3, 12'h3C0);
    @(negedge clk);
    wait_pop("dr_first");
    check("dr_pop", 32'(pop), 32'h8);
    enable = 1'b0;
    @(negedge clk);
    check("dr_c1_pop", 32'(pop), 32'd0);
    check("dr_c1_idle", 32'(idle), 32'd0);
    check("dr_c1_valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    check("dr_c2_valid", 32'(valid_out), 32'd1);
    check("dr_c2_data", 32'(data_out), 32'h3C0);
    check("dr_c2_port", 32'(port_out), 32'd3);
    check("dr_c2_idle", 32'(idle), 32'd0);
    @(negedge clk);
    check("dr_c3_idle", 32'(idle), 32'd1);
    check("dr_c3_valid", 32'(valid_out), 32'd0);

    // Reset the cycle after a pop: the word in flight is discarded.
    push(1, 12'h1D0);
    enable = 1'b1;
    wait_pop("rm_first");
    check("rm_pop", 32'(pop), 32'h2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rm_valid", 32'(valid_out), 32'd0);
    check("rm_pop_after", 32'(pop), 32'd0);
    check("rm_idle", 32'(idle), 32'd1);
    check("rm_err", 32'(err_count), 32'd0);
    check("rm_count", 32'(count_out), 32'd0);
    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      count_sel = 2'(i);
      @(negedge clk);
      check($sformatf("rm_cnt%0d", i), 32'(count_out), 32'd0);
      check($sformatf("rm_novalid%0d", i), 32'(valid_out), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
